// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB initiator and its address decoder.
package apb_pkg;

   localparam int unsigned APB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   // Responder slot index: the address bits above the in-slot offset.
   function automatic int unsigned slot_index(input logic [31:0] addr,
                                              input int unsigned slot_bits);
      return addr >> slot_bits;
   endfunction

endpackage

// File: rtl/apb_initiator_if.sv
// Command/response channel plus APB bus bundle seen by the APB initiator.
interface apb_initiator_if
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned SLAVE_COUNT = 4
) ();

   logic                                    cmd_valid;
   logic                                    cmd_ready;
   logic                                    cmd_write;
   logic [ADDR_WIDTH-1:0]                   cmd_addr;
   logic [APB_DATA_WIDTH-1:0]               cmd_wdata;

   logic                                    rsp_valid;
   logic                                    rsp_ready;
   logic [APB_DATA_WIDTH-1:0]               rsp_rdata;
   logic                                    rsp_error;

   logic [ADDR_WIDTH-1:0]                   apb_PADDR;
   logic [SLAVE_COUNT-1:0]                  apb_PSEL;
   logic                                    apb_PENABLE;
   logic                                    apb_PWRITE;
   logic [APB_DATA_WIDTH-1:0]               apb_PWDATA;
   logic [SLAVE_COUNT-1:0]                  apb_PREADY;
   logic [APB_DATA_WIDTH*SLAVE_COUNT-1:0]   apb_PRDATA;

   // The initiator itself.
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  apb_PREADY, apb_PRDATA,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
      output apb_PADDR, apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PWDATA
   );

   // The surrounding CPU interconnect and responders.
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output apb_PREADY, apb_PRDATA,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
      input  apb_PADDR, apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PWDATA
   );

endinterface

// File: rtl/apb_slot_decode.sv
// Combinational address-to-slot decoder: one-hot responder select plus a hit flag.
module apb_slot_decode
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned SLOT_BITS   = 8,
   parameter int unsigned SLAVE_COUNT = 4
) (
   input  logic [ADDR_WIDTH-1:0]  addr,
   output logic [SLAVE_COUNT-1:0] sel_c,
   output logic                   hit_c
);

   int unsigned slot_idx_c;

   always_comb begin
      slot_idx_c = slot_index(32'(addr), SLOT_BITS);
      sel_c      = '0;
      hit_c      = 1'b0;
      for (int unsigned i = 0; i < SLAVE_COUNT; i++) begin
         if (slot_idx_c == i) begin
            sel_c[i] = 1'b1;
            hit_c    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_initiator.sv
// APB3 initiator: single-outstanding valid/ready commands in, SETUP/ACCESS
// transfers out, with slot decode and a per-transfer PREADY timeout.
module apb_initiator
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned SLOT_BITS   = 8,
   parameter int unsigned SLAVE_COUNT = 4,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic            clk,
   input  logic            reset,
   apb_initiator_if.master bus
);

   localparam int unsigned WAIT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   // Wait count seen on the last permitted ACCESS cycle.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   apb_state_e                state_q,  state_d;
   logic [ADDR_WIDTH-1:0]     paddr_q,  paddr_d;
   logic                      pwrite_q, pwrite_d;
   logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [SLAVE_COUNT-1:0]    sel_q,    sel_d;
   logic [WAIT_W-1:0]         wait_q,   wait_d;
   logic [APB_DATA_WIDTH-1:0] rdata_q,  rdata_d;
   logic                      error_q,  error_d;

   logic [SLAVE_COUNT-1:0]    dec_sel_c;
   logic                      dec_hit_c;
   logic                      pready_sel_c;
   logic [APB_DATA_WIDTH-1:0] prdata_sel_c;
   logic                      timeout_c;

   apb_slot_decode #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .SLOT_BITS   (SLOT_BITS),
      .SLAVE_COUNT (SLAVE_COUNT)
   ) u_decode (
      .addr  (bus.cmd_addr),
      .sel_c (dec_sel_c),
      .hit_c (dec_hit_c)
   );

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         sel_q    <= '0;
         wait_q   <= '0;
         rdata_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         sel_q    <= sel_d;
         wait_q   <= wait_d;
         rdata_q  <= rdata_d;
         error_q  <= error_d;
      end
   end

   // Only the captured slot's PREADY/PRDATA are ever looked at.
   always_comb begin
      pready_sel_c = 1'b0;
      prdata_sel_c = '0;
      for (int unsigned i = 0; i < SLAVE_COUNT; i++) begin
         if (sel_q[i]) begin
            pready_sel_c = bus.apb_PREADY[i];
            prdata_sel_c = bus.apb_PRDATA[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
         end
      end
   end

   assign timeout_c = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

   // Next-state and datapath updates.
   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      sel_d    = sel_q;
      wait_d   = wait_q;
      rdata_d  = rdata_q;
      error_d  = error_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               paddr_d  = bus.cmd_addr;
               pwrite_d = bus.cmd_write;
               pwdata_d = bus.cmd_wdata;
               sel_d    = dec_sel_c;
               rdata_d  = '0;
               error_d  = !dec_hit_c;
               state_d  = dec_hit_c ? SETUP : RESP;
            end
         end
         SETUP: begin
            wait_d  = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            // A ready on the final permitted cycle beats the timeout.
            if (pready_sel_c) begin
               rdata_d = pwrite_q ? '0 : prdata_sel_c;
               error_d = 1'b0;
               state_d = RESP;
            end else if (timeout_c) begin
               rdata_d = '0;
               error_d = 1'b1;
               state_d = RESP;
            end else if (wait_q != '1) begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake and phase outputs decoded from the state register.
   always_comb begin
      bus.cmd_ready   = 1'b0;
      bus.rsp_valid   = 1'b0;
      bus.apb_PSEL    = '0;
      bus.apb_PENABLE = 1'b0;
      case (state_q)
         IDLE:   bus.cmd_ready = 1'b1;
         SETUP:  bus.apb_PSEL  = sel_q;
         ACCESS: begin
            bus.apb_PSEL    = sel_q;
            bus.apb_PENABLE = 1'b1;
         end
         RESP:   bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.apb_PADDR  = paddr_q;
   assign bus.apb_PWRITE = pwrite_q;
   assign bus.apb_PWDATA = pwdata_q;
   assign bus.rsp_rdata  = rdata_q;
   assign bus.rsp_error  = error_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Randomised bench for apb_initiator with a transaction-level timing model,
// plus directed checks for a 3-slave instance with the timeout disabled.
module tb_apb_initiator;
   import apb_pkg::*;

   localparam int unsigned AW  = 12;
   localparam int unsigned SB  = 8;
   localparam int unsigned NS  = 4;
   localparam int unsigned TO  = 4;
   localparam int unsigned NS3 = 3;
   localparam int unsigned DW  = APB_DATA_WIDTH;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   apb_initiator_if #(.ADDR_WIDTH(AW), .SLAVE_COUNT(NS))  bus  ();
   apb_initiator_if #(.ADDR_WIDTH(AW), .SLAVE_COUNT(NS3)) bus3 ();

   apb_initiator #(.ADDR_WIDTH(AW), .SLOT_BITS(SB), .SLAVE_COUNT(NS), .TIMEOUT(TO)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   apb_initiator #(.ADDR_WIDTH(AW), .SLOT_BITS(SB), .SLAVE_COUNT(NS3), .TIMEOUT(0)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model of the transfer in flight, counted in cycles since acceptance.
   logic          chk_en    = 1'b0;
   logic          m_busy    = 1'b0;
   logic          m_hit     = 1'b0;
   logic          m_wr      = 1'b0;
   logic [AW-1:0] m_addr    = '0;
   logic [DW-1:0] m_wd      = '0;
   logic [DW-1:0] m_rd      = '0;
   logic          m_err     = 1'b0;
   logic [NS-1:0] m_sel     = '0;
   int            m_k       = 0;
   int            m_acc_len = 0;
   int            m_rsp_k   = 0;

   // Observations of the current transfer, used by the directed literal checks.
   int            obs_psel   = 0;
   int            obs_acc    = 0;
   int            obs_rsp_k  = 0;
   int            obs_rv     = 0;
   logic [NS-1:0] obs_sel_or = '0;
   logic [DW-1:0] obs_rd     = '0;
   logic          obs_err    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of the main instance against the model.
   always @(negedge clk) begin : cmp_proc
      logic [NS-1:0] e_sel;
      logic          e_pen;
      logic          e_rv;
      if (chk_en) begin
         e_sel = '0;
         e_pen = 1'b0;
         e_rv  = 1'b0;
         if (m_busy) begin
            if (m_hit && m_k >= 1 && m_k <= 1 + m_acc_len) e_sel = m_sel;
            e_pen = m_hit && (m_k >= 2) && (m_k <= 1 + m_acc_len);
            e_rv  = (m_k >= m_rsp_k);
            if (bus.apb_PSEL != '0) obs_psel++;
            if (bus.apb_PENABLE) obs_acc++;
            obs_sel_or = obs_sel_or | bus.apb_PSEL;
            if (bus.rsp_valid) begin
               obs_rv++;
               if (obs_rsp_k == 0) begin
                  obs_rsp_k = m_k;
                  obs_rd    = bus.rsp_rdata;
                  obs_err   = bus.rsp_error;
               end
            end
         end
         check("cmd_ready",   64'(bus.cmd_ready),   64'(!m_busy));
         check("psel",        64'(bus.apb_PSEL),    64'(e_sel));
         check("penable",     64'(bus.apb_PENABLE), 64'(e_pen));
         check("rsp_valid",   64'(bus.rsp_valid),   64'(e_rv));
         check("paddr",       64'(bus.apb_PADDR),   64'(m_addr));
         check("pwrite",      64'(bus.apb_PWRITE),  64'(m_wr));
         check("pwdata",      64'(bus.apb_PWDATA),  64'(m_wd));
         if (e_rv) begin
            check("rsp_error", 64'(bus.rsp_error), 64'(m_err));
            check("rsp_rdata", 64'(bus.rsp_rdata), 64'(m_rd));
         end
      end
   end

   task automatic slave_noise();
      bus.apb_PREADY = NS'($urandom);
      for (int s = 0; s < int'(NS); s++) bus.apb_PRDATA[s*DW +: DW] = $urandom;
   endtask

   task automatic idle_inputs();
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      slave_noise();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         idle_inputs();
         @(posedge clk);
         #1;
      end
   endtask

   // One command: the addressed responder holds PREADY low for 'waits' ACCESS
   // cycles, the host stalls rsp_ready for 'hold' cycles; abort_k>0 pulses reset.
   task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int waits, input logic [DW-1:0] rd, input int hold,
                         input int abort_k);
      int slot;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      bus.rsp_ready = 1'b0;
      slave_noise();
      @(posedge clk);
      #1;
      slot   = int'(addr >> SB);
      m_hit  = (slot < int'(NS));
      m_sel  = m_hit ? NS'(1 << slot) : '0;
      if (!m_hit) begin
         m_acc_len = 0;  m_err = 1'b1; m_rd = '0; m_rsp_k = 1;
      end else if (waits >= int'(TO)) begin
         m_acc_len = int'(TO); m_err = 1'b1; m_rd = '0; m_rsp_k = int'(TO) + 2;
      end else begin
         m_acc_len = waits + 1; m_err = 1'b0; m_rd = wr ? '0 : rd; m_rsp_k = waits + 3;
      end
      m_addr = addr; m_wr = wr; m_wd = wd; m_busy = 1'b1;
      obs_psel = 0; obs_acc = 0; obs_rsp_k = 0; obs_rv = 0; obs_sel_or = '0;
      for (int k = 1; k <= m_rsp_k + hold; k++) begin
         m_k = k;
         bus.cmd_valid = 1'($urandom);
         bus.cmd_write = 1'($urandom);
         bus.cmd_addr  = AW'($urandom);
         bus.cmd_wdata = $urandom;
         slave_noise();
         if (m_hit && k >= 2) begin
            bus.apb_PREADY[slot] = (k >= 2 + waits);
            bus.apb_PRDATA[slot*DW +: DW] = (k >= 2 + waits) ? rd : $urandom;
         end
         bus.rsp_ready = (k >= m_rsp_k + hold) ? 1'b1 : ((k < m_rsp_k) ? 1'($urandom) : 1'b0);
         if (k == abort_k) reset = 1'b1;
         @(posedge clk);
         #1;
         if (k == abort_k) begin
            reset  = 1'b0;
            m_busy = 1'b0;
            m_addr = '0; m_wr = 1'b0; m_wd = '0;
            idle_inputs();
            return;
         end
      end
      m_busy = 1'b0;
      idle_inputs();
   endtask

   initial begin : main
      int k3;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0; bus.apb_PREADY = '0; bus.apb_PRDATA = '0;
      bus3.cmd_valid = 1'b0; bus3.cmd_write = 1'b0; bus3.cmd_addr = '0; bus3.cmd_wdata = '0;
      bus3.rsp_ready = 1'b0; bus3.apb_PREADY = '0; bus3.apb_PRDATA = '0;

      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check("rst_psel",      64'(bus.apb_PSEL),  64'(0));
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("rst_paddr",     64'(bus.apb_PADDR), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(2);

      // Write 0x5 to 0x004, zero-wait slave 0.
      do_txn(1'b1, 12'h004, 32'h5, 0, 32'hDEAD_BEEF, 0, 0);
      check("t1_psel_cycles", 64'(obs_psel),   64'(2));
      check("t1_acc_cycles",  64'(obs_acc),    64'(1));
      check("t1_sel",         64'(obs_sel_or), 64'(4'b0001));
      check("t1_rsp_cycle",   64'(obs_rsp_k),  64'(3));
      check("t1_err",         64'(obs_err),    64'(0));
      check("t1_rdata",       64'(obs_rd),     64'(0));
      check("t1_pwdata",      64'(bus.apb_PWDATA), 64'(32'h5));

      // Read 0x104, slave 1 waits 3 cycles then returns 0x3.
      do_txn(1'b0, 12'h104, 32'h0, 3, 32'h3, 0, 0);
      check("t2_acc_cycles", 64'(obs_acc),    64'(4));
      check("t2_sel",        64'(obs_sel_or), 64'(4'b0010));
      check("t2_rsp_cycle",  64'(obs_rsp_k),  64'(6));
      check("t2_rdata",      64'(obs_rd),     64'(32'h3));

      // Read 0x300, slave 3 never ready: timeout after 4 ACCESS cycles.
      do_txn(1'b0, 12'h300, 32'h0, 100, 32'h77, 0, 0);
      check("t3_acc_cycles", 64'(obs_acc),   64'(4));
      check("t3_rsp_cycle",  64'(obs_rsp_k), 64'(6));
      check("t3_err",        64'(obs_err),   64'(1));
      check("t3_rdata",      64'(obs_rd),    64'(0));

      // Same read, ready arrives on the 4th ACCESS cycle: success wins.
      do_txn(1'b0, 12'h300, 32'h0, 3, 32'h1234_5678, 0, 0);
      check("t4_acc_cycles", 64'(obs_acc), 64'(4));
      check("t4_err",        64'(obs_err), 64'(0));
      check("t4_rdata",      64'(obs_rd),  64'(32'h1234_5678));

      // Decode miss on the 4-slave instance.
      do_txn(1'b0, 12'hA00, 32'h0, 0, 32'h0, 0, 0);
      check("t5_psel_cycles", 64'(obs_psel),  64'(0));
      check("t5_rsp_cycle",   64'(obs_rsp_k), 64'(1));
      check("t5_err",         64'(obs_err),   64'(1));

      // Response held for 5 extra cycles.
      do_txn(1'b0, 12'h208, 32'h0, 1, 32'h0000_ABCD, 5, 0);
      check("t6_rv_cycles", 64'(obs_rv), 64'(6));
      check("t6_rdata",     64'(obs_rd), 64'(32'h0000_ABCD));

      // Reset during ACCESS.
      do_txn(1'b0, 12'h2F0, 32'h0, 10, 32'h0, 0, 2);
      check("t7_psel",      64'(bus.apb_PSEL),    64'(0));
      check("t7_penable",   64'(bus.apb_PENABLE), 64'(0));
      check("t7_rsp_valid", 64'(bus.rsp_valid),   64'(0));
      check("t7_cmd_ready", 64'(bus.cmd_ready),   64'(1));
      idle(3);

      // Randomised traffic.
      for (int n = 0; n < 300; n++) begin
         logic [3:0] sl;
         int         w;
         int         pick;
         sl   = ($urandom_range(0, 5) == 5) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         pick = int'($urandom_range(0, 7));
         w    = (pick < 3) ? 0 : pick - 2;
         do_txn(1'($urandom), {sl, 8'($urandom)}, $urandom, w, $urandom,
                int'($urandom_range(0, 3)), 0);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(2);

      // 3-slave instance: slot 3 is a decode miss.
      bus3.cmd_valid = 1'b1; bus3.cmd_write = 1'b0; bus3.cmd_addr = 12'h300;
      @(posedge clk);
      #1;
      bus3.cmd_valid = 1'b0;
      check("d3_miss_rsp_valid", 64'(bus3.rsp_valid), 64'(1));
      check("d3_miss_err",       64'(bus3.rsp_error), 64'(1));
      check("d3_miss_rdata",     64'(bus3.rsp_rdata), 64'(0));
      check("d3_miss_psel",      64'(bus3.apb_PSEL),  64'(0));
      check("d3_miss_cmd_ready", 64'(bus3.cmd_ready), 64'(0));
      bus3.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus3.rsp_ready = 1'b0;
      check("d3_idle_cmd_ready", 64'(bus3.cmd_ready), 64'(1));

      // Timeout disabled: a 20-cycle wait on slot 2 still completes.
      bus3.cmd_valid = 1'b1; bus3.cmd_addr = 12'h2F0;
      bus3.apb_PRDATA = {32'hCAFE_F00D, 32'h1111_1111, 32'h2222_2222};
      @(posedge clk);
      #1;
      bus3.cmd_valid = 1'b0;
      k3 = 1;
      while (!bus3.rsp_valid && k3 < 60) begin
         bus3.apb_PREADY = (k3 >= 22) ? 3'b100 : 3'b011;
         @(posedge clk);
         #1;
         k3++;
      end
      check("d3_wait_rsp_cycle", 64'(k3),              64'(23));
      check("d3_wait_err",       64'(bus3.rsp_error),  64'(0));
      check("d3_wait_rdata",     64'(bus3.rsp_rdata),  64'(32'hCAFE_F00D));
      bus3.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus3.rsp_ready = 1'b0;
      check("d3_end_cmd_ready", 64'(bus3.cmd_ready), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
